// File: rtl/negator_ctrl.sv
// Word-level sequencer for a bit-serial two's-complement negator: accepts a
// parallel operand, clears the negator, streams the operand LSB-first and
// gathers the serial result into a parallel word.
module negator_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] In_Data,
  input  logic             Abort,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Out_Data,
  output logic             Out_Ovf,
  output logic             Busy,
  output logic             Neg_X,
  output logic             Neg_En,
  output logic             Neg_Reset,
  input  logic             Neg_N
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLR,
    ST_SHIFT,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             ovf_q, ovf_d;

  // NOTE: every signal written here gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    res_d     = res_q;
    ovf_d     = ovf_q;
    In_Ready  = 1'b0;
    Out_Valid = 1'b0;
    Neg_X     = 1'b0;
    Neg_En    = 1'b0;
    Neg_Reset = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        In_Ready = 1'b1;
        if (In_Valid) begin
          op_d    = In_Data;
          cnt_d   = '0;
          ovf_d   = (In_Data == MOST_NEG);
          state_d = ST_CLR;
        end
      end

      ST_CLR: begin
        Neg_Reset = 1'b1;
        Neg_En    = 1'b1;
        state_d   = Abort ? ST_IDLE : ST_SHIFT;
      end

      ST_SHIFT: begin
        Neg_En = 1'b1;
        Neg_X  = op_q[0];
        // The negator answers in the same cycle, so its bit lands at the top
        // and walks down; after WIDTH shifts the first bit sits at the LSB.
        res_d  = {Neg_N, res_q[WIDTH-1:1]};
        op_d   = op_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        if (Abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == LAST_BIT) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        Out_Valid = 1'b1;
        if (Out_Ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Out_Data = res_q;
  assign Out_Ovf  = ovf_q;
  assign Busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_negator_ctrl.sv
// Self-checking bench for negator_ctrl: a WIDTH=4 and a WIDTH=6 instance,
// each wired to a behavioural serial negator, checked against -x mod 2^W.
module tb_negator_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  in_valid = '0;
  logic [1:0]  abort = '0;
  logic [1:0]  out_ready = '0;
  logic [31:0] in_data [2];
  wire  [1:0]  in_ready, out_valid, out_ovf, busy, neg_x, neg_en, neg_reset, neg_n;
  wire  [3:0]  od4;
  wire  [5:0]  od6;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  negator_ctrl #(.WIDTH(4)) dut4 (
    .CLK(clk), .Reset(rst_n), .In_Valid(in_valid[0]), .In_Ready(in_ready[0]),
    .In_Data(in_data[0][3:0]), .Abort(abort[0]), .Out_Valid(out_valid[0]),
    .Out_Ready(out_ready[0]), .Out_Data(od4), .Out_Ovf(out_ovf[0]), .Busy(busy[0]),
    .Neg_X(neg_x[0]), .Neg_En(neg_en[0]), .Neg_Reset(neg_reset[0]), .Neg_N(neg_n[0])
  );

  negator_ctrl #(.WIDTH(6)) dut6 (
    .CLK(clk), .Reset(rst_n), .In_Valid(in_valid[1]), .In_Ready(in_ready[1]),
    .In_Data(in_data[1][5:0]), .Abort(abort[1]), .Out_Valid(out_valid[1]),
    .Out_Ready(out_ready[1]), .Out_Data(od6), .Out_Ovf(out_ovf[1]), .Busy(busy[1]),
    .Neg_X(neg_x[1]), .Neg_En(neg_en[1]), .Neg_Reset(neg_reset[1]), .Neg_N(neg_n[1])
  );

  // Serial negator: copy bits up to and including the first 1, invert after.
  for (genvar g = 0; g < 2; g++) begin : g_neg
    logic seen = 1'b0;
    always @(posedge clk) begin
      if (neg_reset[g]) seen <= 1'b0;
      else if (neg_en[g]) seen <= seen | neg_x[g];
    end
    assign neg_n[g] = neg_en[g] & (neg_x[g] ^ seen);
  end

  function automatic int wdt(input int sel);
    return (sel != 0) ? 6 : 4;
  endfunction

  function automatic logic [31:0] msk(input int sel);
    return (32'd1 << wdt(sel)) - 32'd1;
  endfunction

  function automatic logic [31:0] od(input int sel);
    return (sel != 0) ? {26'd0, od6} : {28'd0, od4};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input int sel, input string tag);
    check({tag, "_in_ready"}, in_ready[sel], 1);
    check({tag, "_out_valid"}, out_valid[sel], 0);
    check({tag, "_busy"}, busy[sel], 0);
    check({tag, "_neg_en"}, neg_en[sel], 0);
    check({tag, "_neg_x"}, neg_x[sel], 0);
    check({tag, "_neg_reset"}, neg_reset[sel], 0);
  endtask

  // One full word: accept, shift, optional backpressure in DONE, release.
  task automatic run_word(input int sel, input logic [31:0] x, input int bp);
    int          w;
    int          guard;
    int          cycles;
    int          k;
    logic [31:0] m;
    logic [31:0] xv;
    logic [31:0] e;
    logic        ovf_e;
    logic [31:0] xs;
    w     = wdt(sel);
    m     = msk(sel);
    xv    = x & m;
    e     = (32'd0 - xv) & m;
    ovf_e = (xv == (32'd1 << (w - 1)));
    guard = 0;
    while (!in_ready[sel] && guard < 100) begin
      tick();
      guard++;
    end
    check("wait_in_ready", in_ready[sel], 1);
    in_valid[sel] = 1'b1;
    in_data[sel]  = xv;
    tick();
    in_valid[sel] = 1'b0;
    in_data[sel]  = $urandom;
    cycles = 0;
    k      = 0;
    xs     = '0;
    while (!out_valid[sel] && cycles < 100) begin
      if (neg_en[sel] && !neg_reset[sel] && k < 32) begin
        xs[k] = neg_x[sel];
        k++;
      end
      tick();
      cycles++;
    end
    check("latency", cycles, w + 1);
    check("shift_count", k, w);
    check("neg_x_seq", xs, xv);
    check("out_data", od(sel), e);
    check("out_ovf", out_ovf[sel], ovf_e);
    check("done_busy", busy[sel], 1);
    check("done_in_ready", in_ready[sel], 0);
    check("done_neg_en", neg_en[sel], 0);
    out_ready[sel] = 1'b0;
    for (int i = 0; i < bp; i++) begin
      in_valid[sel] = 1'($urandom % 2);
      abort[sel]    = 1'($urandom % 2);
      in_data[sel]  = $urandom;
      tick();
      check("bp_out_valid", out_valid[sel], 1);
      check("bp_out_data", od(sel), e);
      check("bp_out_ovf", out_ovf[sel], ovf_e);
      check("bp_in_ready", in_ready[sel], 0);
    end
    in_valid[sel]  = 1'b0;
    abort[sel]     = 1'b0;
    out_ready[sel] = 1'b1;
    tick();
    out_ready[sel] = 1'b0;
    check_idle(sel, "release");
    check("held_out_data", od(sel), e);
  endtask

  initial begin
    int          t [3];
    int          nt;
    int          guard;
    int          seen_valid;
    logic [31:0] x;
    in_data[0] = '0;
    in_data[1] = '0;

    // Reset state
    #12;
    for (int s = 0; s < 2; s++) begin
      check_idle(s, "reset");
      check("reset_out_ovf", out_ovf[s], 0);
      check("reset_out_data", od(s), 0);
    end
    rst_n = 1'b1;
    tick();

    // Directed words
    run_word(0, 32'b1100, 0);
    run_word(1, 32'b011010, 0);
    run_word(1, 32'd0, 2);
    run_word(0, 32'b1000, 0);
    run_word(0, 32'b0001, 0);
    run_word(1, 32'b011010, 6);

    // Back-to-back words with both handshakes held high
    x = $urandom & msk(1);
    in_valid[1]  = 1'b1;
    in_data[1]   = x;
    out_ready[1] = 1'b1;
    nt = 0;
    for (int c = 0; c < 40 && nt < 3; c++) begin
      tick();
      if (out_valid[1]) begin
        t[nt] = c;
        nt++;
        check("b2b_data", od(1), (32'd0 - x) & msk(1));
      end
    end
    check("b2b_words", nt, 3);
    check("b2b_period0", t[1] - t[0], 9);
    check("b2b_period1", t[2] - t[1], 9);
    in_valid[1] = 1'b0;
    guard = 0;
    while (busy[1] && guard < 50) begin
      tick();
      guard++;
    end
    out_ready[1] = 1'b0;
    check("b2b_drain", busy[1], 0);

    // Abort after two SHIFT edges, then a fresh operand
    in_valid[1] = 1'b1;
    in_data[1]  = 32'd26;
    tick();
    in_valid[1] = 1'b0;
    tick();
    tick();
    tick();
    check("pre_abort_busy", busy[1], 1);
    abort[1] = 1'b1;
    tick();
    abort[1] = 1'b0;
    check_idle(1, "abort");
    seen_valid = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (out_valid[1]) seen_valid++;
    end
    check("abort_no_valid", seen_valid, 0);
    run_word(1, 32'd5, 0);

    // Randomized words on both widths
    for (int i = 0; i < 12; i++) begin
      run_word(0, $urandom, $urandom_range(0, 3));
      run_word(1, $urandom, $urandom_range(0, 3));
    end

    // Asynchronous reset in the middle of SHIFT
    in_valid[1] = 1'b1;
    in_data[1]  = 32'b100000;
    tick();
    in_valid[1] = 1'b0;
    tick();
    tick();
    tick();
    check("pre_reset_ovf", out_ovf[1], 1);
    check("pre_reset_neg_en", neg_en[1], 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle(1, "async_reset");
    check("async_reset_ovf", out_ovf[1], 0);
    check("async_reset_data", od(1), 0);
    rst_n = 1'b1;
    tick();
    run_word(1, $urandom, 1);
    run_word(1, 32'b100000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/negator_ctrl.md
Name: negator_ctrl

Overview:
- Word-level sequencer for the bit-serial two's-complement negator (ports X, CLK, En, Reset, N).
- Accepts a parallel WIDTH-bit operand over a valid/ready handshake and clears the negator.
- Shifts the operand into the negator LSB-first and collects the serial result back into a parallel word.
- Presents the result with an overflow flag over a valid/ready handshake; sits between a parallel producer/consumer and one negator instance.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
CLK  input  1  system clock, rising-edge active
Reset  input  1  asynchronous, active-low reset
In_Valid  input  1  producer has an operand on In_Data
In_Ready  output  1  controller can accept an operand
In_Data  input  WIDTH  two's-complement operand
Abort  input  1  synchronous cancel of the operation in flight
Out_Valid  output  1  result available
Out_Ready  input  1  consumer accepts result
Out_Data  output  WIDTH  negated operand (-In_Data mod 2^WIDTH)
Out_Ovf  output  1  operand was the most-negative value (negation overflows)
Busy  output  1  high in any state other than IDLE
Neg_X  output  1  serial bit to negator X
Neg_En  output  1  negator enable
Neg_Reset  output  1  negator synchronous clear, active-high
Neg_N  input  1  negator serial output (Mealy; valid in the same cycle as Neg_X)

Behaviour:
- States: IDLE, CLR, SHIFT, DONE.
- Reset low (asynchronous), whatever the current state:
  - state=IDLE, bit counter=0, operand shift reg=0, result reg=0, Out_Ovf=0.
  - Combinational outputs: In_Ready=1, Out_Valid=0, Busy=0, Neg_X=0, Neg_En=0, Neg_Reset=0.
- IDLE:
  - In_Ready=1; Neg_* all 0.
  - Edge with In_Valid=1:
    - Operand shift reg <= In_Data; counter <= 0.
    - Out_Ovf <= (In_Data == 1<<(WIDTH-1)).
    - State -> CLR.
- CLR (exactly 1 cycle):
  - Neg_Reset=1, Neg_En=1, Neg_X=0; In_Ready=0.
  - Next edge -> SHIFT.
- SHIFT (exactly WIDTH cycles):
  - Neg_En=1, Neg_Reset=0, Neg_X=operand_sr[0].
  - Each edge:
    - result <= {Neg_N, result[WIDTH-1:1]}.
    - operand_sr <= operand_sr >> 1.
    - counter++.
  - Edge with counter==WIDTH-1 -> DONE. Result LSB is the first bit returned.
- DONE:
  - Out_Valid=1; Out_Data=result and Out_Ovf held stable.
  - Neg_En=0.
  - Edge with Out_Ready=1 -> IDLE.
  - Out_Ready may be held low indefinitely with no change to outputs.
- Latency: Out_Valid rises WIDTH+1 cycles after the accepting edge. Minimum period per word is WIDTH+3 cycles (accept, CLR, WIDTH shifts, DONE).
- No new operand is accepted while Busy. In_Ready is combinational from state only; it never depends on In_Valid.
- Abort=1 at an edge in CLR or SHIFT:
  - State -> IDLE; partial result discarded; Out_Valid never asserts for that operand.
  - Negator not cleared here; the next CLR handles that.
  - Abort is ignored in IDLE and DONE.
- Out_Data is registered. It keeps the last result after the DONE->IDLE transition until the next SHIFT overwrites it.
- Zero operand: result 0, Out_Ovf=0.
- Most-negative operand: result equals the operand, Out_Ovf=1.
- Neg_X, Neg_En, Neg_Reset are decoded from state and registers only, with no combinational path from input ports.

Test Plan:
- WIDTH=4, In_Data=4'b1100 (-4):
  - Neg_X sequence 0,0,1,1 in SHIFT; Neg_N returns 0,0,1,0.
  - Out_Data=4'b0100, Out_Ovf=0, Out_Valid exactly 5 cycles after the accept edge.
- WIDTH=6, In_Data=6'b011010 (26) -> Out_Data=6'b100110 (-26), Out_Ovf=0. Then In_Data=0 -> Out_Data=0, Out_Ovf=0.
- WIDTH=4, In_Data=4'b1000 -> Out_Data=4'b1000, Out_Ovf=1. WIDTH=4, In_Data=4'b0001 -> Out_Data=4'b1111.
- Backpressure:
  - Out_Ready held low 6 cycles in DONE: Out_Valid=1 and Out_Data constant; In_Ready=0; In_Valid pulses ignored.
  - Raise Out_Ready -> In_Ready=1 the next cycle.
  - Back-to-back words complete every WIDTH+3 cycles.
- Abort after 2 SHIFT cycles (WIDTH=6, 26):
  - Next cycle IDLE; Out_Valid never asserts.
  - Following operand 5 -> Out_Data=6'b111011, confirming the negator was re-cleared.
- Reset low asynchronously mid-SHIFT (between edges):
  - Busy=0, In_Ready=1, Neg_En=0, Out_Ovf=0 immediately.
  - After release, a fresh operand completes correctly.
